// File: rtl/pulse_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pulse_pkg
//  Description : Shared definitions for the pulse stretcher: state encodings,
//                the state enum built on them, and width helper functions.
//  Revision    : 1.0 - initial release
// ============================================================================
package pulse_pkg;

    // Raw state encodings. The enum below is built on these values so the
    // encoding stays visible to anything that inspects the state register.
    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] HIGH = 2'b01;
    localparam logic [1:0] GAP  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = IDLE,
        ST_HIGH = HIGH,
        ST_GAP  = GAP
    } state_e;

    // Ceiling log2 for elaboration-time width computation.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(v)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Width of the phase counter: clog2 of the longer phase, at least 1 bit.
    // The counter only ever holds (phase length - 1), so clog2 is enough.
    function automatic int unsigned cnt_width(input int unsigned high_cycles,
                                              input int unsigned low_cycles);
        int unsigned m;
        int unsigned w;
        m = (high_cycles > low_cycles) ? high_cycles : low_cycles;
        w = clog2(m);
        return (w < 1) ? 1 : w;
    endfunction

endpackage : pulse_pkg
`default_nettype wire

// File: rtl/load_down_counter.sv
`default_nettype none
// ============================================================================
//  Module      : load_down_counter
//  Description : Loadable down counter with zero flag. Load has priority over
//                decrement. Decrementing at zero wraps; the owner never does
//                that because it reloads on zero.
//  Ports       : clk        - clock, rising edge
//                reset      - asynchronous active-high reset (q -> 0)
//                load_i     - load load_val_i this cycle
//                load_val_i - value to load
//                dec_i      - decrement by one this cycle
//                q_o        - current count
//                zero_o     - q_o == 0
//  Revision    : 1.0 - initial release
// ============================================================================
module load_down_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic [W-1:0] q_o,
    output logic         zero_o
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (load_i) begin
            q_d = load_val_i;
        end else if (dec_i) begin
            q_d = q_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o    = q_q;
    assign zero_o = (q_q == '0);

endmodule : load_down_counter
`default_nettype wire

// File: rtl/pulse_stretch.sv
`default_nettype none
// ============================================================================
//  Module      : pulse_stretch
//  Description : Turns single-cycle ticks into pulses of HIGH_CYCLES cycles
//                followed by a guard gap of at least LOW_CYCLES cycles. Ticks
//                arriving while a pulse or gap is running are queued in a
//                saturating counter and replayed back to back.
//  Ports       : clk        - clock, rising edge
//                reset      - asynchronous active-high reset
//                tick_i     - event request, one per cycle sampled high
//                level_o    - stretched pulse output
//                busy_o     - high while a pulse or gap is in progress
//                pending_o  - number of queued ticks
//                overflow_o - one-cycle flag: a tick was dropped
//  Revision    : 1.0 - initial release
// ============================================================================
module pulse_stretch
    import pulse_pkg::*;
#(
    parameter int HIGH_CYCLES = 4,
    parameter int LOW_CYCLES  = 3,
    parameter int PEND_W      = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick_i,
    output logic              level_o,
    output logic              busy_o,
    output logic [PEND_W-1:0] pending_o,
    output logic              overflow_o
);

    localparam int unsigned        c_cnt_w     = cnt_width(HIGH_CYCLES, LOW_CYCLES);
    localparam logic [c_cnt_w-1:0] c_high_load = c_cnt_w'(HIGH_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_low_load  = c_cnt_w'(LOW_CYCLES - 1);
    localparam logic [PEND_W-1:0]  c_pend_max  = {PEND_W{1'b1}};

    state_e              state_q;
    state_e              state_d;

    logic                cnt_load;
    logic [c_cnt_w-1:0]  cnt_load_val;
    logic                cnt_dec;
    logic [c_cnt_w-1:0]  cnt_q;
    logic                cnt_zero;

    logic                pend_inc;
    logic                pend_consume;
    logic [PEND_W-1:0]   pending_q;
    logic [PEND_W-1:0]   pending_d;
    logic                overflow_q;
    logic                overflow_d;

    // ------------------------------------------------------------------------
    // Phase counter: counts down the remaining cycles of HIGH or GAP.
    // ------------------------------------------------------------------------
    load_down_counter #(
        .W (c_cnt_w)
    ) u_cnt (
        .clk        (clk),
        .reset      (reset),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .dec_i      (cnt_dec),
        .q_o        (cnt_q),
        .zero_o     (cnt_zero)
    );

    // ------------------------------------------------------------------------
    // FSM next state, counter control and queue requests.
    // ------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;
        pend_inc     = 1'b0;
        pend_consume = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Tick is consumed directly; the queue is not involved.
                if (tick_i) begin
                    state_d      = ST_HIGH;
                    cnt_load     = 1'b1;
                    cnt_load_val = c_high_load;
                end
            end

            ST_HIGH: begin
                pend_inc = tick_i;
                if (cnt_zero) begin
                    state_d      = ST_GAP;
                    cnt_load     = 1'b1;
                    cnt_load_val = c_low_load;
                end else begin
                    cnt_dec = 1'b1;
                end
            end

            ST_GAP: begin
                if (!cnt_zero) begin
                    cnt_dec  = 1'b1;
                    pend_inc = tick_i;
                end else if (pending_q != '0) begin
                    // Replay a queued tick. A concurrent tick takes its place
                    // in the queue, which the inc/consume pair nets to zero.
                    state_d      = ST_HIGH;
                    cnt_load     = 1'b1;
                    cnt_load_val = c_high_load;
                    pend_consume = 1'b1;
                    pend_inc     = tick_i;
                end else if (tick_i) begin
                    state_d      = ST_HIGH;
                    cnt_load     = 1'b1;
                    cnt_load_val = c_high_load;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Saturating pending-tick counter and drop flag.
    // ------------------------------------------------------------------------
    always_comb begin
        pending_d  = pending_q;
        overflow_d = 1'b0;
        if (pend_inc && !pend_consume) begin
            if (pending_q == c_pend_max) begin
                overflow_d = 1'b1;
            end else begin
                pending_d = pending_q + 1'b1;
            end
        end else if (pend_consume && !pend_inc) begin
            pending_d = pending_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            pending_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
        end
    end

    // Outputs decode the state register only; tick never reaches level
    // without passing through a flop.
    assign level_o    = (state_q == ST_HIGH);
    assign busy_o     = (state_q != ST_IDLE);
    assign pending_o  = pending_q;
    assign overflow_o = overflow_q;

endmodule : pulse_stretch
`default_nettype wire

// File: doc/pulse_stretch.md
# pulse_stretch

Converts single-cycle event ticks into clean, timed output levels with guaranteed minimum high and low durations; it is the driving-side counterpart of the switch debouncer, turning internal ticks into well-formed pulses. Ticks that arrive while a pulse or guard gap is in progress are queued in a saturating counter and replayed in order. Typical use: driving LEDs, strobes or external enables from `db_tick`-style events.

## Interface

- `HIGH_CYCLES`, default 4: length of each output pulse in clk cycles; must be ≥ 1.
- `LOW_CYCLES`, default 3: minimum low gap after each pulse, in clk cycles; must be ≥ 1.
- `PEND_W`, default 2: width of the pending-tick counter; the counter saturates at 2^PEND_W−1.
- `clk` input 1: clock, rising edge.
- `reset` input 1: reset, asynchronous, active-high.
- `tick` input 1: event request, one request per cycle sampled high.
- `level` output 1: stretched pulse, registered.
- `busy` output 1: high while state ≠ IDLE.
- `pending` output PEND_W: number of queued ticks, registered.
- `overflow` output 1: registered one-cycle flag marking a dropped tick.

## Operation

- States:
  - IDLE: `level` = 0.
  - HIGH: `level` = 1.
  - GAP: `level` = 0, guard period.
- Counter `cnt` has width clog2(max(HIGH_CYCLES, LOW_CYCLES)) with a floor of 1 bit.
- IDLE: if `tick` is high, go to HIGH and load `cnt` = HIGH_CYCLES−1. `pending` stays 0, because the tick is consumed directly. In IDLE, `pending` is always 0.
- HIGH: if `cnt` = 0, go to GAP and load `cnt` = LOW_CYCLES−1; otherwise decrement `cnt`.
- GAP: if `cnt` ≠ 0, decrement `cnt`. If `cnt` = 0:
  - `pending` > 0: go to HIGH, load HIGH_CYCLES−1, consume one pending tick.
  - `pending` = 0 and `tick`: go to HIGH, consume the tick.
  - otherwise: go to IDLE.
- In HIGH, or in GAP while not consuming, a `tick` increments `pending`.
- When a consume and a `tick` occur in the same cycle, `pending` is unchanged: the new tick replaces the consumed one.
- When `pending` is saturated and a `tick` arrives with no consume, the tick is dropped and `overflow` = 1 on the next cycle only.
- Invalid state encoding goes to IDLE.
- `level` is derived from registered state only; no combinational path from `tick` to `level`.

## Timing

- Reset (asynchronous, mid-operation included) gives immediately: state IDLE, `cnt` 0, `pending` 0, `level` 0, `busy` 0, `overflow` 0. Queued ticks are lost.
- A tick sampled at edge k in IDLE gives:
  - `level` = 1 after edge k, held for exactly HIGH_CYCLES cycles.
  - `level` = 0 after edge k+HIGH_CYCLES.
- Back-to-back pulse period is exactly HIGH_CYCLES+LOW_CYCLES. The next pulse rises after edge k+HIGH_CYCLES+LOW_CYCLES when work is pending at the end of GAP.
- `busy` deasserts after edge k+HIGH_CYCLES+LOW_CYCLES if nothing is pending.
- `pending` updates on the edge that samples the tick and is visible the following cycle.
- `overflow` is high during the cycle after the edge that sampled the dropped tick.
- A `tick` held high for N cycles counts as N requests.

## Structure

- Shared package `pulse_pkg` holds:
  - state localparams: IDLE = 2'b00, HIGH = 2'b01, GAP = 2'b10.
  - a clog2 helper function, if one is not already present.
- One sub-module: `load_down_counter`.
  - Parameter: width W.
  - Inputs: `load`, `load_val`, `dec`.
  - Outputs: `q`, `zero`.
  - Same async reset.
  - Instantiated once for `cnt`.
- Pending-counter saturation logic and the FSM stay in `pulse_stretch`.

## Test plan

All scenarios use HIGH_CYCLES=4, LOW_CYCLES=3, PEND_W=2 unless stated.

1. Assert `reset`, clock 5 cycles → `level`, `busy`, `pending`, `overflow` all 0. Release `reset`, `tick` = 0 → all outputs remain 0.
2. Single `tick` at edge 10:
   - `level` = 1 for edges 10–13.
   - `level` = 0 from edge 14.
   - `busy` = 1 for edges 10–16, 0 from edge 17.
3. `tick` high for 3 consecutive cycles starting at edge 10:
   - Three pulses rise after edges 10, 17 and 24.
   - `pending` reads 1 then 2 after the ticks, 1 after edge 17, 0 after edge 24.
4. `tick` high for 5 consecutive cycles from idle:
   - One tick consumed, `pending` saturates at 3.
   - Fifth tick dropped, `overflow` = 1 for exactly one cycle.
   - Exactly 4 pulses emitted, each spaced 7 cycles apart.
5. With `pending` = 1, assert `tick` on the GAP-end cycle (`cnt` = 0) → next pulse starts, `pending` stays 1, and a further pulse follows 7 cycles later.
6. Assert `reset` during the second cycle of HIGH with `pending` = 2 → `level` drops without waiting for a clock edge, `pending` = 0. After release with no ticks, no further pulses.
